// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch stage of the pipelined MIPS datapath.
//   fetch_state_e : prefetch request FSM (IDLE / REQ / DISCARD)
//   NOP_INSTR     : instruction presented to decode when nothing is valid
//   WORD_ADDR_W   : word-address width (PC[31:2])
package pipe_pkg;

    localparam int unsigned WORD_ADDR_W = 30;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, PC+1} entries.
// Ports:
//   i_clk, i_rst      clock / asynchronous active-high reset
//   i_push, i_wdata   write one entry (ignored when full)
//   i_pop             drop the head entry (ignored when empty)
//   i_flush           empty the FIFO; overrides push and pop
//   o_empty           no entry present
//   o_head            entry at the read pointer (combinational)
//   o_count           occupancy, 0..DEPTH
module prefetch_fifo
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 62
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_empty,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             do_push;

    assign o_empty = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign o_count = wptr_q - rptr_q;
    assign o_head  = mem_q[rptr_q[AW-1:0]];
    assign do_push = i_push && !full && !i_flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (i_flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push)            wptr_d = wptr_q + PTR_ONE;
            if (i_pop && !o_empty)  rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: issues word-address fetches over a req/ack
// handshake, buffers returned words with their PC+1 tags and presents the
// head entry to decode. A redirect flushes the buffer and discards any
// response still in flight.
// Ports:
//   i_clk, i_rst                    clock / asynchronous active-high reset
//   o_mem_req, o_mem_addr           fetch request and its word address
//   i_mem_ack, i_mem_data           response strobe and instruction word
//   i_redirect, i_redirect_addr     jump/branch taken and its target
//   i_stall                         decode hold, head is not consumed
//   o_valid, o_instr, o_npc         head entry (NOP / 0 when empty)
//   o_count                         buffer occupancy
// Optional build macro PREFETCH_STATS_EN adds saturating counters
//   o_stat_fetched, o_stat_dropped, o_stat_stall_cyc.
module instr_prefetch_unit
    import pipe_pkg::*;
#(
    parameter int unsigned            DEPTH      = 4,
    parameter int unsigned            ADDR_WIDTH = WORD_ADDR_W,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    output logic                      o_mem_req,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    input  logic                      i_mem_ack,
    input  logic [DATA_WIDTH-1:0]     i_mem_data,
    input  logic                      i_redirect,
    input  logic [ADDR_WIDTH-1:0]     i_redirect_addr,
    input  logic                      i_stall,
    output logic                      o_valid,
    output logic [DATA_WIDTH-1:0]     o_instr,
    output logic [ADDR_WIDTH-1:0]     o_npc,
    output logic [$clog2(DEPTH):0]    o_count
`ifdef PREFETCH_STATS_EN
   ,output logic [31:0]               o_stat_fetched,
    output logic [31:0]               o_stat_dropped,
    output logic [31:0]               o_stat_stall_cyc
`endif
);

    localparam int unsigned           CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    fetch_state_e                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]            fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]            mem_addr_q, mem_addr_d;
    logic [ADDR_WIDTH-1:0]            next_pc;
    logic                             push, pop;
    logic                             fifo_empty;
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]                 fifo_count;
    logic [CNT_W-1:0]                 count_after;

    assign next_pc     = fetch_pc_q + ADDR_ONE;
    assign pop         = !fifo_empty && !i_stall && !i_redirect;
    assign count_after = fifo_count + CNT_ONE - CNT_W'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_redirect) begin
                    fetch_pc_d = i_redirect_addr;
                end else if (fifo_count < DEPTH_C) begin
                    state_d    = REQ;
                    mem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (i_redirect) begin
                    fetch_pc_d = i_redirect_addr;
                    state_d    = i_mem_ack ? IDLE : DISCARD;
                end else if (i_mem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = next_pc;
                    // Chain the next request only if this cycle's push/pop leaves room.
                    if (count_after < DEPTH_C) begin
                        mem_addr_d = next_pc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                // Address stays on the abandoned request until its ack drains.
                if (i_redirect) fetch_pc_d = i_redirect_addr;
                if (i_mem_ack)  state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH + ADDR_WIDTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_wdata ({i_mem_data, next_pc}),
        .i_pop   (pop),
        .i_flush (i_redirect),
        .o_empty (fifo_empty),
        .o_head  (fifo_head),
        .o_count (fifo_count)
    );

    assign o_mem_req  = (state_q != IDLE);
    assign o_mem_addr = mem_addr_q;
    assign o_valid    = !fifo_empty;
    assign o_instr    = fifo_empty ? DATA_WIDTH'(NOP_INSTR)
                                   : fifo_head[DATA_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
    assign o_npc      = fifo_empty ? '0 : fifo_head[ADDR_WIDTH-1:0];
    assign o_count    = fifo_count;

`ifdef PREFETCH_STATS_EN
    logic [31:0] stat_fetched_q, stat_dropped_q, stat_stall_q;
    logic        ack_drop;

    assign ack_drop = i_mem_ack && (((state_q == REQ) && i_redirect) || (state_q == DISCARD));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stat_fetched_q <= '0;
            stat_dropped_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            if (push && (stat_fetched_q != '1))            stat_fetched_q <= stat_fetched_q + 32'd1;
            if (ack_drop && (stat_dropped_q != '1))        stat_dropped_q <= stat_dropped_q + 32'd1;
            if (i_stall && o_valid && (stat_stall_q != '1)) stat_stall_q  <= stat_stall_q + 32'd1;
        end
    end

    assign o_stat_fetched   = stat_fetched_q;
    assign o_stat_dropped   = stat_dropped_q;
    assign o_stat_stall_cyc = stat_stall_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
module tb_instr_prefetch_unit;

    localparam int DEPTH = 4;
    localparam int AW    = 30;
    localparam int DW    = 32;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          o_mem_req;
    logic [AW-1:0] o_mem_addr;
    logic          i_mem_ack = 1'b0;
    logic [DW-1:0] i_mem_data = '0;
    logic          i_redirect = 1'b0;
    logic [AW-1:0] i_redirect_addr = '0;
    logic          i_stall = 1'b0;
    logic          o_valid;
    logic [DW-1:0] o_instr;
    logic [AW-1:0] o_npc;
    logic [2:0]    o_count;
`ifdef PREFETCH_STATS_EN
    logic [31:0]   o_stat_fetched, o_stat_dropped, o_stat_stall_cyc;
`endif

    always #5 i_clk = ~i_clk;

    instr_prefetch_unit #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (30'h0)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .o_mem_req       (o_mem_req),
        .o_mem_addr      (o_mem_addr),
        .i_mem_ack       (i_mem_ack),
        .i_mem_data      (i_mem_data),
        .i_redirect      (i_redirect),
        .i_redirect_addr (i_redirect_addr),
        .i_stall         (i_stall),
        .o_valid         (o_valid),
        .o_instr         (o_instr),
        .o_npc           (o_npc),
        .o_count         (o_count)
`ifdef PREFETCH_STATS_EN
       ,.o_stat_fetched   (o_stat_fetched),
        .o_stat_dropped   (o_stat_dropped),
        .o_stat_stall_cyc (o_stat_stall_cyc)
`endif
    );

    int ncheck = 0;
    int nerr   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncheck++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [29:0] npc;
    } ent_t;

    ent_t        mq[$];
    bit          m_out;     // a request is outstanding
    bit          m_drop;    // its response will be thrown away
    logic [29:0] m_addr;
    logic [29:0] m_pc;
    int          m_fetched, m_dropped, m_stallc;
    int          m_sz;
    bit          m_ack;

    always @(posedge i_clk) begin
        if (i_rst) begin
            mq.delete();
            m_out = 0; m_drop = 0; m_addr = '0; m_pc = 30'h0;
            m_fetched = 0; m_dropped = 0; m_stallc = 0;
        end else begin
            m_sz  = mq.size();
            m_ack = m_out && i_mem_ack;
            if (m_sz > 0 && i_stall) m_stallc++;
            if (i_redirect)              mq.delete();
            else if (m_sz > 0 && !i_stall) void'(mq.pop_front());
            if (!m_out) begin
                if (i_redirect) m_pc = i_redirect_addr;
                else if (m_sz < DEPTH) begin
                    m_out = 1; m_drop = 0; m_addr = m_pc;
                end
            end else if (m_ack) begin
                if (m_drop || i_redirect) begin
                    m_dropped++;
                    m_out = 0;
                    if (i_redirect) m_pc = i_redirect_addr;
                end else begin
                    mq.push_back('{instr: i_mem_data, npc: m_addr + 30'd1});
                    m_fetched++;
                    m_pc = m_addr + 30'd1;
                    if (mq.size() < DEPTH) m_addr = m_pc;
                    else m_out = 0;
                end
            end else if (i_redirect) begin
                m_drop = 1;
                m_pc   = i_redirect_addr;
            end
        end
    end

    // ---------------- per-cycle compare + delivery log ----------------
    logic [29:0] dq_npc[$];
    logic [31:0] dq_instr[$];
    int          delivered;
    int          maxcnt;
    bit          saw_addr2;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            chk("valid", 64'(o_valid), 64'(mq.size() > 0));
            chk("count", 64'(o_count), 64'(mq.size()));
            chk("mem_req", 64'(o_mem_req), 64'(m_out));
            if (m_out) chk("mem_addr", 64'(o_mem_addr), 64'(m_addr));
            if (mq.size() > 0) begin
                chk("instr", 64'(o_instr), 64'(mq[0].instr));
                chk("npc", 64'(o_npc), 64'(mq[0].npc));
            end else begin
                chk("instr_nop", 64'(o_instr), 64'h0);
            end
`ifdef PREFETCH_STATS_EN
            chk("stat_fetched", 64'(o_stat_fetched), 64'(m_fetched));
            chk("stat_dropped", 64'(o_stat_dropped), 64'(m_dropped));
            chk("stat_stall", 64'(o_stat_stall_cyc), 64'(m_stallc));
`endif
            if (int'(o_count) > maxcnt) maxcnt = int'(o_count);
            if (o_valid && o_npc == 30'h3) saw_addr2 = 1;
            if (o_valid && !i_stall && !i_redirect) begin
                delivered++;
                dq_npc.push_back(o_npc);
                dq_instr.push_back(o_instr);
            end
        end
    end

    // ---------------- memory responder + stimulus ----------------
    int lat      = 0;
    bit rnd_mode = 0;
    int age      = 0;
    bit prev_req = 0;

    task automatic cycle();
        bit ack_prev;
        @(posedge i_clk);
        #1;
        i_redirect = 1'b0;
        ack_prev   = i_mem_ack;
        if (!o_mem_req) begin
            age       = 0;
            i_mem_ack = 1'b0;
        end else begin
            if (ack_prev || !prev_req) age = 0;
            else age++;
            i_mem_ack = rnd_mode ? ($urandom_range(2) == 0) : (age >= lat);
        end
        i_mem_data = rnd_mode ? DW'($urandom) : ({2'b00, o_mem_addr} ^ 32'hA5A5_0000);
        prev_req   = o_mem_req;
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_stall = 1'b0;
        repeat (2) cycle();
        i_rst = 1'b0;
        dq_npc.delete();
        dq_instr.delete();
        delivered = 0;
        maxcnt    = 0;
        saw_addr2 = 0;
    endtask

    task automatic wait_req_addr(input logic [29:0] a, input int budget, input string name);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            cycle();
            if (o_mem_req && o_mem_addr == a) found = 1;
        end
        chk(name, 64'(found), 64'h1);
    endtask

    int flushed;
    bit found;

    initial begin
        // ---- 1: back-to-back fetch, ack every cycle ----
        lat = 0; rnd_mode = 0;
        do_reset();
        chk("rst_mem_req", 64'(o_mem_req), 64'h0);
        chk("rst_valid", 64'(o_valid), 64'h0);
        chk("rst_instr", 64'(o_instr), 64'h0);
        chk("rst_npc", 64'(o_npc), 64'h0);
        chk("rst_count", 64'(o_count), 64'h0);
        cycle();
        chk("lat1_valid", 64'(o_valid), 64'h0);
        cycle();
        chk("lat2_valid", 64'(o_valid), 64'h1);
        chk("lat2_instr", 64'(o_instr), 64'hA5A5_0000);
        chk("lat2_npc", 64'(o_npc), 64'h1);
        repeat (20) cycle();
        chk("s1_delivered", 64'(dq_npc.size() >= 4), 64'h1);
        for (int i = 0; i < 4 && i < dq_npc.size(); i++) begin
            chk("s1_seq_instr", 64'(dq_instr[i]), 64'(32'hA5A5_0000 + 32'(i)));
            chk("s1_seq_npc", 64'(dq_npc[i]), 64'(i + 1));
        end
        chk("s1_maxcount", 64'(maxcnt <= 4), 64'h1);

        // ---- 2: decode stall fills the buffer ----
        do_reset();
        i_stall = 1'b1;
        repeat (10) cycle();
        chk("s2_full_count", 64'(o_count), 64'h4);
        chk("s2_req_idle", 64'(o_mem_req), 64'h0);
        chk("s2_head_npc", 64'(o_npc), 64'h1);
        i_stall = 1'b0;
        found = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (i == 4) chk("s2_four_pops", 64'(dq_npc.size()), 64'h4);
            if (o_mem_req && !found) begin
                found = 1;
                chk("s2_resume_addr", 64'(o_mem_addr), 64'h4);
            end
        end
        chk("s2_resumed", 64'(found), 64'h1);
        for (int i = 0; i < 4 && i < dq_npc.size(); i++)
            chk("s2_pop_npc", 64'(dq_npc[i]), 64'(i + 1));

        // ---- 3: redirect while the addr-2 request is pending ----
        lat = 3;
        do_reset();
        wait_req_addr(30'h2, 40, "s3_req2_timeout");
        flushed         = mq.size();
        i_redirect      = 1'b1;
        i_redirect_addr = 30'h10;
        wait_req_addr(30'h10, 20, "s3_req10_timeout");
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (o_valid) begin
                found = 1;
                chk("s3_first_npc", 64'(o_npc), 64'h11);
            end
        end
        chk("s3_valid_timeout", 64'(found), 64'h1);
        repeat (10) cycle();
        chk("s3_no_addr2", 64'(saw_addr2), 64'h0);
`ifdef PREFETCH_STATS_EN
        chk("s3_stat_dropped", 64'(o_stat_dropped), 64'h1);
        chk("s3_stat_fetched", 64'(o_stat_fetched), 64'(delivered + flushed + mq.size()));
`endif

        // ---- 4: redirect coinciding with ack and a would-be pop ----
        lat = 0;
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (o_valid && o_mem_req && i_mem_ack) found = 1;
        end
        chk("s4_setup_timeout", 64'(found), 64'h1);
        i_redirect      = 1'b1;
        i_redirect_addr = 30'h20;
        cycle();
        chk("s4_count", 64'(o_count), 64'h0);
        chk("s4_valid", 64'(o_valid), 64'h0);
        chk("s4_instr", 64'(o_instr), 64'h0);
        wait_req_addr(30'h20, 5, "s4_req_target");

        // ---- 5: reset mid-request, stray ack right after release ----
        lat = 6;
        do_reset();
        wait_req_addr(30'h0, 5, "s5_req_timeout");
        i_rst = 1'b1;
        #1;
        chk("s5_async_req", 64'(o_mem_req), 64'h0);
        repeat (2) cycle();
        i_rst     = 1'b0;
        i_mem_ack = 1'b1;
        lat       = 0;
        cycle();
        chk("s5_ack_ignored", 64'(o_count), 64'h0);
        chk("s5_first_req", 64'(o_mem_req && o_mem_addr == 30'h0), 64'h1);
        cycle();
        chk("s5_first_npc", 64'(o_npc), 64'h1);

        // ---- 6: randomized traffic ----
        rnd_mode = 1;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            cycle();
            i_stall = ($urandom_range(3) == 0);
            if ($urandom_range(11) == 0) begin
                i_redirect      = 1'b1;
                i_redirect_addr = ($urandom_range(3) == 0) ? (30'h3FFF_FFFE + AW'($urandom_range(1)))
                                                           : AW'($urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
